alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: MUL_EN, default 1, enables the multi-cycle MUL opcode 8'h0E; when 0, 8'h0E is an illegal opcode.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_op  input  8  opcode.
REQ-007 req_a, req_b  input  16 each  operands (r1, r2).
REQ-008 rsp_valid  output  1  result present.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_data  output  16  result.
REQ-011 rsp_err  output  1  illegal opcode flag for this response.
REQ-012 flags  output  8  status register: bit0 C, bit2 L, bit5 F (overflow), bit6 Z, bit7 N; other bits always 0.
REQ-013 alu_r1, alu_r2  output  16 each  operands driven to the external combinational ALU.
REQ-014 alu_op  output  8  opcode driven to the ALU.
REQ-015 alu_rout  input  16  ALU result, combinational from alu_r1/alu_r2/alu_op.

Function
REQ-016 States: IDLE, EXEC, MUL, DONE; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on req_valid, latch op/a/b; go to EXEC for single-cycle opcodes, MUL for 8'h0E with MUL_EN=1, DONE with rsp_err=1 for any other opcode.
REQ-018 Legal single-cycle opcodes: 01 AND, 02 OR, 03 XOR, 04 NOT, 05 ADD, 06 ADDU, 07 ADDC, 08 RSH, 09 SUB, 0B CMP, 0C ALSH, 0F ARSH, 84 LSH (hex).
REQ-019 EXEC: drive alu_op=op, alu_r1=a, alu_r2=b, capture alu_rout into rsp_data, update flags, go to DONE; request-accept to rsp_valid latency SHALL be 2 cycles.
REQ-020 ADDC: controller SHALL drive alu_op=8'h05, alu_r1=a, alu_r2=b+C (16-bit wrap), so C is consumed from flags, not from the ALU.
REQ-021 Flags computed internally from 17-bit arithmetic on latched operands: ADD/ADDC: C=carry-out of a+b(+C), F=signed overflow; SUB/CMP: C=carry-out of a+~b+1, F=signed overflow of a-b; CMP additionally L=(a<b unsigned); ADDU leaves C,F unchanged; logic/shift ops leave C,F,L unchanged.
REQ-022 Z=(result==0) and N=result[15] SHALL update for every legal opcode; for CMP, result = a-b and rsp_data = a-b.
REQ-023 MUL: 16 iterations, one per cycle, iteration i drives alu_op=8'h05, alu_r1=acc, alu_r2=(a<<i) when b[i]=1 else 16'h0000; acc<=alu_rout; acc starts 0.
REQ-024 MUL result is low 16 bits of a*b; flags Z,N updated, C,F,L unchanged; latency accept to rsp_valid = 17 cycles.
REQ-025 Outside EXEC and MUL, alu_op SHALL be 8'h00 and alu_r1/alu_r2 SHALL be 0.
REQ-026 DONE: rsp_valid=1; rsp_data/rsp_err held stable until rsp_valid&&rsp_ready, then return to IDLE (no same-cycle new accept).
REQ-027 Illegal opcode: rsp_data=0, rsp_err=1, flags unchanged; latency 1 cycle.
REQ-028 rsp_err SHALL be 0 for every legal-opcode response.

Reset
REQ-029 On reset assertion, asynchronously: state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, flags=8'h00, acc=0, iteration counter=0.
REQ-030 Reset mid-EXEC or mid-MUL SHALL abort the operation with no response and no flag update.
REQ-031 After reset release, req_ready=1 in the first cycle.

Verification
REQ-032 ADD a=16'h7FFF, b=16'h0001 -> rsp_data=16'h8000, flags C=0 F=1 Z=0 N=1, rsp_valid 2 cycles after accept.
REQ-033 ADD a=16'hFFFF, b=16'h0001 then ADDC a=16'h0000, b=16'h0000 -> first 16'h0000 with C=1 Z=1; second 16'h0001 with C=0.
REQ-034 CMP a=16'h0003, b=16'h0005 -> rsp_data=16'hFFFE, L=1, N=1, Z=0; CMP a=5, b=5 -> Z=1, L=0.
REQ-035 MUL a=16'h0123, b=16'h0045 -> rsp_data=16'h4E6F after exactly 17 cycles; with MUL_EN=0 -> rsp_err=1, rsp_data=0.
REQ-036 rsp_ready held 0 for 5 cycles after DONE -> rsp_data stable, req_ready=0, no second accept.
REQ-037 Reset asserted at MUL iteration 8 -> rsp_valid never asserts, flags=0, req_ready=1 after release.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: request/response sequencer for an external combinational 16-bit ALU.
// A request is accepted in idle. Single-cycle opcodes go through the ALU in one exec
// cycle. MUL (8'h0E) runs 16 shift-and-add iterations through the ALU's ADD path.
// Illegal opcodes respond immediately with rsp_err set.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake; req_op, req_a, req_b carry the request
//   rsp_valid/rsp_ready      response handshake; rsp_data, rsp_err carry the response
//   flags                    status register: bit0 C, bit2 L, bit5 F, bit6 Z, bit7 N
//   alu_op/alu_r1/alu_r2     ALU operands; alu_rout is the combinational ALU result
module alu_seq_ctrl #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  flags,
  output logic [15:0] alu_r1,
  output logic [15:0] alu_r2,
  output logic [7:0]  alu_op,
  input  logic [15:0] alu_rout
);

  localparam logic [7:0] OpAnd  = 8'h01;
  localparam logic [7:0] OpOr   = 8'h02;
  localparam logic [7:0] OpXor  = 8'h03;
  localparam logic [7:0] OpNot  = 8'h04;
  localparam logic [7:0] OpAdd  = 8'h05;
  localparam logic [7:0] OpAddu = 8'h06;
  localparam logic [7:0] OpAddc = 8'h07;
  localparam logic [7:0] OpRsh  = 8'h08;
  localparam logic [7:0] OpSub  = 8'h09;
  localparam logic [7:0] OpCmp  = 8'h0B;
  localparam logic [7:0] OpAlsh = 8'h0C;
  localparam logic [7:0] OpMul  = 8'h0E;
  localparam logic [7:0] OpArsh = 8'h0F;
  localparam logic [7:0] OpLsh  = 8'h84;

  localparam int unsigned FlagC = 0;
  localparam int unsigned FlagL = 2;
  localparam int unsigned FlagF = 5;
  localparam int unsigned FlagZ = 6;
  localparam int unsigned FlagN = 7;

  typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  flags_q, flags_d;

  logic        single_op;
  logic        cin;
  logic [16:0] add_sum;
  logic [16:0] sub_sum;
  logic        add_ovf;
  logic        sub_ovf;
  logic [15:0] result;

  assign single_op = req_op inside {OpAnd, OpOr, OpXor, OpNot, OpAdd, OpAddu, OpAddc, OpRsh,
                                    OpSub, OpCmp, OpAlsh, OpArsh, OpLsh};

  // Flag arithmetic is done locally on the latched operands, not derived from the ALU.
  always_comb begin
    cin     = (op_q == OpAddc) ? flags_q[FlagC] : 1'b0;
    add_sum = {1'b0, a_q} + {1'b0, b_q} + {16'h0000, cin};
    sub_sum = {1'b0, a_q} + {1'b0, ~b_q} + 17'd1;
    add_ovf = (a_q[15] == b_q[15]) && (add_sum[15] != a_q[15]);
    sub_ovf = (a_q[15] != b_q[15]) && (sub_sum[15] != a_q[15]);
    result  = (op_q == OpCmp) ? sub_sum[15:0] : alu_rout;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    flags_d    = flags_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_op     = 8'h00;
    alu_r1     = 16'h0000;
    alu_r2     = 16'h0000;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d       = req_op;
          a_d        = req_a;
          b_d        = req_b;
          acc_d      = 16'h0000;
          cnt_d      = 4'd0;
          rsp_data_d = 16'h0000;
          rsp_err_d  = 1'b0;
          if (single_op) begin
            state_d = StExec;
          end else if (MUL_EN && (req_op == OpMul)) begin
            state_d = StMul;
          end else begin
            rsp_err_d = 1'b1;
            state_d   = StDone;
          end
        end
      end

      StExec: begin
        // ADDC is issued as ADD with the carry folded into r2.
        alu_op = (op_q == OpAddc) ? OpAdd : op_q;
        alu_r1 = a_q;
        alu_r2 = (op_q == OpAddc) ? (b_q + {15'h0000, cin}) : b_q;
        rsp_data_d     = result;
        flags_d[FlagZ] = (result == 16'h0000);
        flags_d[FlagN] = result[15];
        case (op_q)
          OpAdd, OpAddc: begin
            flags_d[FlagC] = add_sum[16];
            flags_d[FlagF] = add_ovf;
          end
          OpSub: begin
            flags_d[FlagC] = sub_sum[16];
            flags_d[FlagF] = sub_ovf;
          end
          OpCmp: begin
            flags_d[FlagC] = sub_sum[16];
            flags_d[FlagF] = sub_ovf;
            flags_d[FlagL] = (a_q < b_q);
          end
          default: ;
        endcase
        state_d = StDone;
      end

      StMul: begin
        // Shift-and-add: one partial product per cycle through the ALU adder.
        alu_op = OpAdd;
        alu_r1 = acc_q;
        alu_r2 = b_q[cnt_q] ? (a_q << cnt_q) : 16'h0000;
        acc_d  = alu_rout;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          rsp_data_d     = alu_rout;
          flags_d[FlagZ] = (alu_rout == 16'h0000);
          flags_d[FlagN] = alu_rout[15];
          state_d        = StDone;
        end
      end

      StDone: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= 8'h00;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      acc_q      <= 16'h0000;
      cnt_q      <= 4'd0;
      rsp_data_q <= 16'h0000;
      rsp_err_q  <= 1'b0;
      flags_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      flags_q    <= flags_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign flags    = flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench for alu_seq_ctrl.
// Provides a combinational ALU, a behavioural reference model of responses, flags and
// latency, directed boundary cases, randomized traffic, a MUL_EN=0 instance and a
// mid-MUL reset.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  flags;
  logic [15:0] alu_r1, alu_r2, alu_rout;
  logic [7:0]  alu_op;

  // Second instance with MUL disabled; it never uses its ALU port for that case.
  logic        req_valid_nm, req_ready_nm, rsp_valid_nm, rsp_ready_nm, rsp_err_nm;
  logic [15:0] rsp_data_nm, alu_r1_nm, alu_r2_nm, alu_rout_nm;
  logic [7:0]  flags_nm, alu_op_nm;

  int n_checks = 0;
  int n_errors = 0;
  bit run_mon = 1'b0;

  logic [7:0]  m_flags;
  logic [15:0] obs_data;
  logic [7:0]  obs_flags;
  int          obs_lat;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .flags(flags),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_op(alu_op), .alu_rout(alu_rout)
  );

  alu_seq_ctrl #(.MUL_EN(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .req_valid(req_valid_nm), .req_ready(req_ready_nm),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_nm),
    .rsp_ready(rsp_ready_nm), .rsp_data(rsp_data_nm), .rsp_err(rsp_err_nm),
    .flags(flags_nm), .alu_r1(alu_r1_nm), .alu_r2(alu_r2_nm), .alu_op(alu_op_nm),
    .alu_rout(alu_rout_nm)
  );

  assign alu_rout_nm = 16'h0000;

  // External ALU.
  always_comb begin
    case (alu_op)
      8'h01:        alu_rout = alu_r1 & alu_r2;
      8'h02:        alu_rout = alu_r1 | alu_r2;
      8'h03:        alu_rout = alu_r1 ^ alu_r2;
      8'h04:        alu_rout = ~alu_r1;
      8'h05, 8'h06: alu_rout = alu_r1 + alu_r2;
      8'h08:        alu_rout = alu_r1 >> alu_r2[3:0];
      8'h09, 8'h0B: alu_rout = alu_r1 - alu_r2;
      8'h0C, 8'h84: alu_rout = alu_r1 << alu_r2[3:0];
      8'h0F:        alu_rout = $signed(alu_r1) >>> alu_r2[3:0];
      default:      alu_rout = 16'h0000;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected data, error and latency; advances the model flags.
  task automatic model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit mul_en, output logic [15:0] d, output bit err,
                       output int lat);
    int ia, ib, s, p, sh;
    bit c, f, l;
    c = m_flags[0]; l = m_flags[2]; f = m_flags[5];
    ia = $signed(a); ib = $signed(b); sh = int'(b[3:0]);
    err = 1'b0; lat = 2; d = 16'h0000;
    case (op)
      8'h01: d = a & b;
      8'h02: d = a | b;
      8'h03: d = a ^ b;
      8'h04: d = ~a;
      8'h05, 8'h07: begin
        s = int'(a) + int'(b) + ((op == 8'h07) ? int'(c) : 0);
        d = s[15:0];
        c = (s > 65535);
        s = ia + ib + ((op == 8'h07) ? int'(c ? m_flags[0] : m_flags[0]) : 0);
        f = (s > 32767) || (s < -32768);
      end
      8'h06: d = a + b;
      8'h08: d = a >> sh;
      8'h09, 8'h0B: begin
        d = a - b;
        c = (a >= b);
        s = ia - ib;
        f = (s > 32767) || (s < -32768);
        if (op == 8'h0B) l = (a < b);
      end
      8'h0C, 8'h84: d = a << sh;
      8'h0F: begin
        s = ia >>> sh;
        d = s[15:0];
      end
      8'h0E: begin
        if (mul_en) begin
          p = int'(a) * int'(b);
          d = p[15:0];
          lat = 17;
        end else begin
          err = 1'b1; lat = 1;
        end
      end
      default: begin
        err = 1'b1; lat = 1;
      end
    endcase
    if (!err) m_flags = {d[15], (d == 16'h0000), f, 2'b00, l, 1'b0, c};
  endtask

  // One full transaction on the main instance; hold = cycles rsp_ready stays low.
  task automatic txn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                     input int hold);
    logic [15:0] ed;
    bit ee;
    int el, lat, w;
    model(op, a, b, 1'b1, ed, ee, el);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 8'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency op%0h", op), lat, el);
    chk($sformatf("rsp_data op%0h a%0h b%0h", op, a, b), rsp_data, ed);
    chk($sformatf("rsp_err op%0h", op), rsp_err, ee);
    chk($sformatf("flags op%0h a%0h b%0h", op, a, b), flags, m_flags);
    obs_data = rsp_data; obs_flags = flags; obs_lat = lat;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_op = 8'h05;
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_no_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("back_idle", req_ready, 1);
  endtask

  // Every-cycle invariants: ALU port quiet outside exec/mul, reserved flag bits zero.
  always @(negedge clk) begin
    if (run_mon && !reset) begin
      if (req_ready || rsp_valid)
        chk("alu_quiet", (alu_op == 8'h00 && alu_r1 == 16'h0 && alu_r2 == 16'h0), 1);
      chk("ready_valid_excl", req_ready && rsp_valid, 0);
      chk("flags_rsvd", flags & 8'h1A, 0);
    end
  end

  logic [7:0] ops [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                           8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84, 8'h0E};

  initial begin
    logic [7:0]  rop;
    logic [15:0] ra, rb;
    bit          saw;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_op = 8'h00;
    req_a = 16'h0; req_b = 16'h0; req_valid_nm = 1'b0; rsp_ready_nm = 1'b0;
    m_flags = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_flags", flags, 0);
    reset = 1'b0;
    run_mon = 1'b1;
    @(negedge clk);
    chk("first_ready", req_ready, 1);

    txn(8'h05, 16'h7FFF, 16'h0001, 0);
    chk("lit_add_data", obs_data, 16'h8000);
    chk("lit_add_flags", obs_flags, 8'hA0);
    chk("lit_add_lat", obs_lat, 2);
    txn(8'h05, 16'hFFFF, 16'h0001, 0);
    chk("lit_addcy_data", obs_data, 16'h0000);
    chk("lit_addcy_flags", obs_flags, 8'h41);
    txn(8'h07, 16'h0000, 16'h0000, 0);
    chk("lit_addc_data", obs_data, 16'h0001);
    chk("lit_addc_flags", obs_flags, 8'h00);
    txn(8'h0B, 16'h0003, 16'h0005, 0);
    chk("lit_cmp_data", obs_data, 16'hFFFE);
    chk("lit_cmp_flags", obs_flags, 8'h84);
    txn(8'h0B, 16'h0005, 16'h0005, 0);
    chk("lit_cmpeq_flags", obs_flags, 8'h41);
    txn(8'h0E, 16'h0123, 16'h0045, 5);
    chk("lit_mul_data", obs_data, 16'h4E6F);
    chk("lit_mul_lat", obs_lat, 17);
    chk("lit_mul_flags", obs_flags, 8'h01);
    txn(8'hFF, 16'h1234, 16'h5678, 1);
    chk("lit_ill_data", obs_data, 16'h0000);
    chk("lit_ill_lat", obs_lat, 1);

    // MUL with MUL_EN=0 must be rejected.
    chk("nm_ready", req_ready_nm, 1);
    req_op = 8'h0E; req_a = 16'h0123; req_b = 16'h0045; req_valid_nm = 1'b1;
    @(negedge clk);
    req_valid_nm = 1'b0;
    chk("nm_valid", rsp_valid_nm, 1);
    chk("nm_err", rsp_err_nm, 1);
    chk("nm_data", rsp_data_nm, 0);
    chk("nm_flags", flags_nm, 0);
    rsp_ready_nm = 1'b1;
    @(negedge clk);
    rsp_ready_nm = 1'b0;
    chk("nm_idle", req_ready_nm, 1);

    for (int i = 0; i < 150; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      rop = (k < 14) ? ops[k] : 8'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
      txn(rop, ra, rb, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a multiply.
    txn(8'h05, 16'hFFFF, 16'h0001, 0);
    req_op = 8'h0E; req_a = 16'h1234; req_b = 16'hFFFF; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mrst_valid", rsp_valid, 0);
    chk("mrst_flags", flags, 0);
    m_flags = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_ready", req_ready, 1);
    saw = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    chk("mrst_no_rsp", saw, 0);
    chk("mrst_flags_after", flags, 0);

    run_mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
